// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 datapath mux.
// Grants are held for a burst (last or MAX_BURST beats) into a one-entry output register.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a0_valid,
  input  logic [WIDTH-1:0] a0_data,
  input  logic             a0_last,
  output logic             a0_ready,
  input  logic             a1_valid,
  input  logic [WIDTH-1:0] a1_data,
  input  logic             a1_last,
  output logic             a1_ready,
  output logic             s,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             y_src,
  input  logic             y_ready
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  localparam logic [7:0] CntLast = 8'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_last_q, y_last_d;
  logic             y_src_q, y_src_d;

  logic             space;
  logic             granted;
  logic             gnt_idx;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             accept;
  logic             burst_end;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    y_src_d   = y_src_q;

    space     = !y_valid_q || y_ready;
    granted   = (state_q != StIdle);
    gnt_idx   = (state_q == StGnt1);
    sel_valid = gnt_idx ? a1_valid : a0_valid;
    sel_data  = gnt_idx ? a1_data  : a0_data;
    sel_last  = gnt_idx ? a1_last  : a0_last;
    accept    = granted && sel_valid && space;
    burst_end = sel_last || (cnt_q == CntLast);

    a0_ready  = (state_q == StGnt0) && space;
    a1_ready  = (state_q == StGnt1) && space;

    unique case (state_q)
      StIdle: begin
        // Contention resolves to prio; a lone requester wins regardless.
        if (a0_valid && (!a1_valid || !prio_q)) begin
          state_d = StGnt0;
          s_d     = 1'b0;
        end else if (a1_valid) begin
          state_d = StGnt1;
          s_d     = 1'b1;
        end
      end
      StGnt0, StGnt1: begin
        if (accept && burst_end) begin
          state_d = StIdle;
          prio_d  = !gnt_idx;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      y_valid_d = 1'b1;
      y_data_d  = sel_data;
      y_last_d  = burst_end;
      y_src_d   = gnt_idx;
      cnt_d     = burst_end ? 8'd0 : cnt_q + 8'd1;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      prio_q    <= 1'b0;
      cnt_q     <= 8'd0;
      s_q       <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
      y_src_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
      y_src_q   <= y_src_d;
    end
  end

  assign s       = s_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign y_src   = y_src_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: random source bursts checked by a transaction-level
// grant-order model through a scoreboard, plus directed reset and latency checks.
module tb_mux2_rr_arbiter;

  localparam int Width    = 8;
  localparam int MaxBurst = 4;

  typedef struct packed {
    logic [Width-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [Width-1:0] data;
    logic             last;
    logic             src;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             a0_valid, a0_last, a0_ready;
  logic [Width-1:0] a0_data;
  logic             a1_valid, a1_last, a1_ready;
  logic [Width-1:0] a1_data;
  logic             s;
  logic             y_valid, y_last, y_src, y_ready;
  logic [Width-1:0] y_data;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];
  int    n_checks;
  int    n_fail;
  bit    mon_en;

  mux2_rr_arbiter #(
    .WIDTH    (Width),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a0_valid(a0_valid),
    .a0_data (a0_data),
    .a0_last (a0_last),
    .a0_ready(a0_ready),
    .a1_valid(a1_valid),
    .a1_data (a1_data),
    .a1_last (a1_last),
    .a1_ready(a1_ready),
    .s       (s),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_src   (y_src),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Grant order from the arbitration rules: alternate on contention, bursts end on
  // last or after MaxBurst beats. Always starts from a freshly reset priority of 0.
  task automatic build_expected();
    int    i0, i1, cnt;
    logic  p, r, done;
    beat_t b;
    i0 = 0;
    i1 = 0;
    p  = 1'b0;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) r = p;
      else r = (i0 < q0.size()) ? 1'b0 : 1'b1;
      cnt  = 0;
      done = 1'b0;
      while (!done) begin
        if (r) begin
          b = q1[i1];
          i1++;
        end else begin
          b = q0[i0];
          i0++;
        end
        cnt++;
        done = b.last || (cnt == MaxBurst);
        exp_q.push_back({b.data, done, r});
      end
      p = !r;
    end
  endtask

  // Sources only stall mid-segment so that both are valid at every arbitration point.
  task automatic run_random(input int n0, input int n1, input int lastpct);
    int    idx0, idx1, seg0, seg1, cyc;
    logic  acc0, acc1;
    beat_t b;
    q0.delete();
    q1.delete();
    for (int k = 0; k < n0; k++) begin
      b.data = Width'($urandom);
      b.last = ($urandom_range(99) < lastpct) || (k == n0 - 1);
      q0.push_back(b);
    end
    for (int k = 0; k < n1; k++) begin
      b.data = Width'($urandom);
      b.last = ($urandom_range(99) < lastpct) || (k == n1 - 1);
      q1.push_back(b);
    end
    build_expected();
    idx0 = 0; idx1 = 0; seg0 = 0; seg1 = 0; cyc = 0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    while ((idx0 < n0 || idx1 < n1 || exp_q.size() != 0) && cyc < 5000) begin
      a0_valid = (idx0 < n0) && (seg0 == 0 || $urandom_range(3) != 0);
      a0_data  = (idx0 < n0) ? q0[idx0].data : '0;
      a0_last  = (idx0 < n0) ? q0[idx0].last : 1'b0;
      a1_valid = (idx1 < n1) && (seg1 == 0 || $urandom_range(3) != 0);
      a1_data  = (idx1 < n1) ? q1[idx1].data : '0;
      a1_last  = (idx1 < n1) ? q1[idx1].last : 1'b0;
      y_ready  = ($urandom_range(9) < 7);
      @(negedge clk);
      acc0 = a0_valid && a0_ready;
      acc1 = a1_valid && a1_ready;
      @(posedge clk);
      #1;
      if (acc0) begin
        seg0++;
        if (q0[idx0].last || seg0 == MaxBurst) seg0 = 0;
        idx0++;
      end
      if (acc1) begin
        seg1++;
        if (q1[idx1].last || seg1 == MaxBurst) seg1 = 0;
        idx1++;
      end
      cyc++;
    end
    a0_valid = 1'b0;
    a1_valid = 1'b0;
    mon_en   = 1'b0;
    check("sources_drained", 32'(idx0 + idx1), 32'(n0 + n1));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every output handshake pops one expected beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && y_valid && y_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data=%0h last=%0b src=%0b, expected none",
                   y_data, y_last, y_src);
        end else begin
          e = exp_q.pop_front();
          check("beat{data,last,src}", 32'({y_data, y_last, y_src}), 32'({e.data, e.last, e.src}));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    a0_valid = 1'b0; a0_data = '0; a0_last = 1'b0;
    a1_valid = 1'b0; a1_data = '0; a1_last = 1'b0;
    y_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a0_ready", 32'(a0_ready), 32'd0);
    check("rst_a1_ready", 32'(a1_ready), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_y_data", 32'(y_data), 32'd0);
    check("rst_y_last", 32'(y_last), 32'd0);
    check("rst_y_src", 32'(y_src), 32'd0);
    rst = 1'b0;

    run_random(30, 30, 15);

    // Lone a1 request: one arbitration cycle, then a1 granted and beats flow.
    @(posedge clk);
    #1;
    y_ready  = 1'b1;
    a1_valid = 1'b1;
    a1_data  = 8'h5A;
    a1_last  = 1'b0;
    @(negedge clk);
    check("arb_cycle_a1_ready", 32'(a1_ready), 32'd0);
    check("arb_cycle_y_valid", 32'(y_valid), 32'd0);
    @(negedge clk);
    check("gnt1_a1_ready", 32'(a1_ready), 32'd1);
    check("gnt1_a0_ready", 32'(a0_ready), 32'd0);
    check("gnt1_s", 32'(s), 32'd1);
    @(negedge clk);
    check("gnt1_y_valid", 32'(y_valid), 32'd1);
    check("gnt1_y_data", 32'(y_data), 32'h5A);
    check("gnt1_y_src", 32'(y_src), 32'd1);

    // Asynchronous reset mid-burst.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_y_valid", 32'(y_valid), 32'd0);
    check("async_rst_a1_ready", 32'(a1_ready), 32'd0);
    check("async_rst_s", 32'(s), 32'd0);
    a1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_random(20, 15, 35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 2:1 datapath multiplexer between two streaming sources.
- Drives the mux select and locks the grant for a whole burst, delimited by last or by a beat limit.
- Registers the selected beat into a single-entry valid/ready output stage.
- Sits in front of any shared consumer (bus port, ALU operand path) fed by two producers.

Parameters:
- WIDTH, 8, data width of each requester channel and of the output.
- MAX_BURST, 16, maximum beats per grant before forced release; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- a0_valid  input  1  requester 0 has a beat
- a0_data  input  WIDTH  requester 0 beat data
- a0_last  input  1  requester 0 final beat of burst
- a0_ready  output  1  requester 0 beat accepted this cycle when high with a0_valid
- a1_valid  input  1  requester 1 has a beat
- a1_data  input  WIDTH  requester 1 beat data
- a1_last  input  1  requester 1 final beat of burst
- a1_ready  output  1  requester 1 beat accepted this cycle when high with a1_valid
- s  output  1  mux select in effect: 0 selects a0 channel, 1 selects a1 channel
- y_valid  output  1  output register holds a beat
- y_data  output  WIDTH  registered beat data
- y_last  output  1  registered last flag; also high on the forced-release beat
- y_src  output  1  index of the requester that supplied the registered beat
- y_ready  input  1  consumer accepts the beat when high with y_valid

Behaviour:
- Reset (rst high, asynchronous):
  - state=IDLE, prio=0, beat count=0.
  - s=0, a0_ready=0, a1_ready=0, y_valid=0, y_data=0, y_last=0, y_src=0.
  - Takes effect immediately, even mid-burst; partial bursts are abandoned and nothing resumes.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - a0_ready=a1_ready=0.
  - Only a0_valid high -> GNT0. Only a1_valid high -> GNT1.
  - Both high -> GNT(prio). Neither high -> stay in IDLE.
  - Arbitration costs one cycle: no beat is accepted in the cycle the grant is decided.
- s follows the state: GNT0 -> 0, GNT1 -> 1. In IDLE, s holds its last value.
- GNTi, space and acceptance:
  - space = !y_valid || y_ready.
  - ai_ready = space. The other requester's ready = 0.
  - Accept = ai_valid && ai_ready.
- On accept:
  - y_data <= ai_data, y_src <= i, y_valid <= 1.
  - y_last <= ai_last || (count == MAX_BURST-1).
  - count increments.
- No accept while y_ready is high: y_valid <= 0.
- Burst end (accepted beat with ai_last, or count reaches MAX_BURST):
  - Next state is IDLE, prio <= ~i, count <= 0.
  - The end-of-burst beat is the last beat accepted under that grant.
- Back-to-back bursts from the same requester are allowed only when the other requester is not valid in IDLE. Otherwise the grant alternates.
- Throughput and latency:
  - Full throughput in GNTi when y_ready is held high: 1 beat per cycle.
  - Latency is 1 cycle from accept to y_valid.
- Output stability: while y_valid && !y_ready, y_data, y_last and y_src hold stable.
- Deasserting ai_valid mid-burst does not release the grant; the arbiter waits in GNTi.
- MAX_BURST=1 forces release after every beat.
- Count width is 8 bits.

Test Plan:
- Reset, then a0_valid=1 only with a 3-beat burst (last on beat 3), y_ready=1 -> s=0; a0_ready high for 3 cycles starting 1 cycle after request; y_data shows beats 1 cycle later; y_last on the 3rd; state returns to IDLE with prio=1.
- Both valid with continuous 2-beat bursts, y_ready=1 -> grants alternate 0,1,0,1; y_src sequence 0,0,1,1,0,0,1,1; one idle arbitration cycle between bursts.
- Grant on a1 with y_ready=0 for 4 cycles after the first beat -> a1_ready=0; y_data/y_src stable; no data lost. After y_ready=1, the remaining beats drain in order.
- MAX_BURST=4, a0 streams 10 beats with no last, a1 valid -> forced release after beat 4 with y_last=1; a1 is granted next; a0 resumes after a1's burst.
- Assert rst in the middle of a GNT1 burst with y_valid=1 -> y_valid, a1_ready and s drop to 0 asynchronously; after release, simultaneous requests grant a0 first (prio=0).
